// File: rtl/mem_wb_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_if
// Description : MEM-stage inputs and WB-stage outputs of the MEM/WB register.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_wb_if #(
    parameter int CNT_W = 32
);
    // MEM-stage side
    logic              valid_MEM;
    logic [31:0]       Instruction_MEM;
    logic [31:0]       alu_result_MEM;
    logic [31:0]       Mem_read_data;
    logic [31:0]       pc_plus4_MEM;
    logic [4:0]        w1_num_MEM;
    logic              RegWrite_MEM;
    logic              MemtoReg_MEM;
    logic              Jal_MEM;

    // WB-stage side
    logic              valid_WB;
    logic [31:0]       Instruction_WB;
    logic [4:0]        w1_num_WB;
    logic [31:0]       w1_data_WB;
    logic              RegWrite_WB;
    logic              addr_err_WB;
    logic [CNT_W-1:0]  retired_count;

    modport master (
        output valid_MEM, Instruction_MEM, alu_result_MEM, Mem_read_data,
               pc_plus4_MEM, w1_num_MEM, RegWrite_MEM, MemtoReg_MEM, Jal_MEM,
        input  valid_WB, Instruction_WB, w1_num_WB, w1_data_WB,
               RegWrite_WB, addr_err_WB, retired_count
    );

    modport slave (
        input  valid_MEM, Instruction_MEM, alu_result_MEM, Mem_read_data,
               pc_plus4_MEM, w1_num_MEM, RegWrite_MEM, MemtoReg_MEM, Jal_MEM,
        output valid_WB, Instruction_WB, w1_num_WB, w1_data_WB,
               RegWrite_WB, addr_err_WB, retired_count
    );
endinterface
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage
// Description : MEM/WB pipeline register with load formatting, write-back
//               select and retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage #(
    parameter int CNT_W = 32
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic stall,
    input  wire logic flush,
    mem_wb_if.slave   bus
);
    localparam logic [5:0] c_OP_LB  = 6'h20;
    localparam logic [5:0] c_OP_LH  = 6'h21;
    localparam logic [5:0] c_OP_LW  = 6'h23;
    localparam logic [5:0] c_OP_LBU = 6'h24;
    localparam logic [5:0] c_OP_LHU = 6'h25;

    logic [5:0]       w_opcode;
    logic [1:0]       w_byte_addr;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_load_data;
    logic             w_misaligned;
    logic             w_addr_err;
    logic [31:0]      w_wb_data;
    logic             w_reg_write;

    logic             r_valid;
    logic [31:0]      r_instr;
    logic [4:0]       r_w1_num;
    logic [31:0]      r_w1_data;
    logic             r_reg_write;
    logic             r_addr_err;
    logic [CNT_W-1:0] r_retired;

    assign w_opcode    = bus.Instruction_MEM[31:26];
    assign w_byte_addr = bus.alu_result_MEM[1:0];
    assign w_half      = w_byte_addr[1] ? bus.Mem_read_data[31:16]
                                        : bus.Mem_read_data[15:0];

    always_comb begin
        w_byte = bus.Mem_read_data[7:0];
        case (w_byte_addr)
            2'd0:    w_byte = bus.Mem_read_data[7:0];
            2'd1:    w_byte = bus.Mem_read_data[15:8];
            2'd2:    w_byte = bus.Mem_read_data[23:16];
            default: w_byte = bus.Mem_read_data[31:24];
        endcase
    end

    // Sub-word alignment and extension; unknown load opcodes pass the word through.
    always_comb begin
        w_load_data  = bus.Mem_read_data;
        w_misaligned = 1'b0;
        case (w_opcode)
            c_OP_LW: begin
                w_load_data  = bus.Mem_read_data;
                w_misaligned = (w_byte_addr != 2'd0);
            end
            c_OP_LB: begin
                w_load_data  = {{24{w_byte[7]}}, w_byte};
            end
            c_OP_LBU: begin
                w_load_data  = {24'd0, w_byte};
            end
            c_OP_LH: begin
                w_load_data  = {{16{w_half[15]}}, w_half};
                w_misaligned = w_byte_addr[0];
            end
            c_OP_LHU: begin
                w_load_data  = {16'd0, w_half};
                w_misaligned = w_byte_addr[0];
            end
            default: begin
                w_load_data  = bus.Mem_read_data;
                w_misaligned = 1'b0;
            end
        endcase
    end

    // A link write never faults, even if MemtoReg is also set.
    assign w_addr_err  = bus.valid_MEM & bus.MemtoReg_MEM & ~bus.Jal_MEM & w_misaligned;

    assign w_wb_data   = bus.Jal_MEM      ? bus.pc_plus4_MEM :
                         bus.MemtoReg_MEM ? w_load_data      :
                                            bus.alu_result_MEM;

    assign w_reg_write = bus.RegWrite_MEM & bus.valid_MEM &
                         (bus.w1_num_MEM != 5'd0) & ~w_addr_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_instr     <= 32'd0;
            r_w1_num    <= 5'd0;
            r_w1_data   <= 32'd0;
            r_reg_write <= 1'b0;
            r_addr_err  <= 1'b0;
            r_retired   <= '0;
        end else if (flush) begin
            r_valid     <= 1'b0;
            r_instr     <= 32'd0;
            r_w1_num    <= 5'd0;
            r_w1_data   <= 32'd0;
            r_reg_write <= 1'b0;
            r_addr_err  <= 1'b0;
        end else if (!stall) begin
            r_valid     <= bus.valid_MEM;
            r_instr     <= bus.Instruction_MEM;
            r_w1_num    <= bus.w1_num_MEM;
            r_w1_data   <= w_wb_data;
            r_reg_write <= w_reg_write;
            r_addr_err  <= w_addr_err;
            if (bus.valid_MEM) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    assign bus.valid_WB       = r_valid;
    assign bus.Instruction_WB = r_instr;
    assign bus.w1_num_WB      = r_w1_num;
    assign bus.w1_data_WB     = r_w1_data;
    assign bus.RegWrite_WB    = r_reg_write;
    assign bus.addr_err_WB    = r_addr_err;
    assign bus.retired_count  = r_retired;

endmodule
`default_nettype wire

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
MEM/WB pipeline register and write-back formatting for the 5-stage MIPS pipeline. It sits directly downstream of the data-memory stage and captures the word read from data RAM, the ALU result, the link address and the destination register number on the rising clock edge. It aligns and extends sub-word loads, selects the write-back value, and presents a registered write port to the register file and the forwarding unit. It also keeps a retired-instruction counter.

Parameters:
CNT_W, 32, width of retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
clk  input  1  pipeline clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
stall  input  1  hold all WB-stage registers this cycle
flush  input  1  load a bubble this cycle (overrides stall)
valid_MEM  input  1  MEM stage holds a real instruction
Instruction_MEM  input  32  instruction word in MEM
alu_result_MEM  input  32  ALU result; also the data address
Mem_read_data  input  32  word from data RAM; valid before rising clk
pc_plus4_MEM  input  32  PC+4 of the MEM instruction (link value)
w1_num_MEM  input  5  destination register number, already resolved for Jal/RegDst
RegWrite_MEM  input  1  instruction writes the register file
MemtoReg_MEM  input  1  write-back value comes from memory
Jal_MEM  input  1  write-back value is the link address
valid_WB  output  1  WB holds a real instruction
Instruction_WB  output  32  registered instruction word
w1_num_WB  output  5  register-file write address
w1_data_WB  output  32  register-file write data
RegWrite_WB  output  1  register-file write enable
addr_err_WB  output  1  captured load was misaligned
retired_count  output  CNT_W  count of valid instructions captured into WB

Behaviour:
- Reset (rst=1, asynchronous, any time): all outputs go to 0, including retired_count. An instruction in flight is dropped.
- Priority at each rising edge: rst > flush > stall > capture.
- flush: valid_WB=0, RegWrite_WB=0, addr_err_WB=0, Instruction_WB=0, w1_num_WB=0, w1_data_WB=0. retired_count does not change.
- stall (without flush): every register holds its value, including retired_count.
- Capture: valid_WB<=valid_MEM.
  - RegWrite_WB<=RegWrite_MEM & valid_MEM & (w1_num_MEM!=0). Writes to $0 are always suppressed.
  - retired_count increments by 1 when valid_MEM=1 and wraps from all-ones to 0.
- Latency: exactly 1 cycle from MEM inputs to WB outputs. There is no combinational path from any input to any output.
- Write-back select at capture, in priority order:
  - Jal_MEM: pc_plus4_MEM.
  - MemtoReg_MEM: formatted load data (see load formatting).
  - Otherwise: alu_result_MEM.
- Load formatting uses opcode = Instruction_MEM[31:26] and a = alu_result_MEM[1:0]. Byte lane k = Mem_read_data[8k+7:8k] (little-endian).
  - 0x23 lw: full word. addr_err = (a!=0).
  - 0x20 lb: lane a, sign-extended.
  - 0x24 lbu: lane a, zero-extended.
  - 0x21 lh: halfword Mem_read_data[16*a[1]+15:16*a[1]], sign-extended. addr_err = a[0].
  - 0x25 lhu: same halfword, zero-extended. addr_err = a[0].
  - Any other opcode with MemtoReg_MEM=1: full word, addr_err=0.
- Misaligned loads:
  - addr_err_WB<=1 and RegWrite_WB<=0; the register file is not written.
  - valid_WB and retired_count still update normally.
- addr_err_WB is 0 whenever MemtoReg_MEM=0, Jal_MEM=1, or valid_MEM=0.
- Bubble input (valid_MEM=0, no stall/flush): captured as a bubble. RegWrite_WB=0; the data fields load the input values unchanged.
- flush and stall together: flush wins and a bubble is loaded.

Test Plan:
1. Reset: assert rst mid-cycle with valid state loaded -> every output 0 immediately (asynchronous). Release, feed lw $5 at addr 0x10 with Mem_read_data=0xDEADBEEF -> next cycle w1_num_WB=5, w1_data_WB=0xDEADBEEF, RegWrite_WB=1, retired_count=1.
2. Sub-word loads with Mem_read_data=0x80FF7F01:
   - lb at a=3 -> 0xFFFFFF80
   - lbu at a=3 -> 0x00000080
   - lh at a=2 -> 0xFFFF80FF
   - lhu at a=0 -> 0x00007F01
3. Misaligned loads: lw at a=2 -> addr_err_WB=1, RegWrite_WB=0, valid_WB=1. lh at a=1 -> same response.
4. Jal with pc_plus4_MEM=0x00400024, w1_num_MEM=31, MemtoReg_MEM=1 -> w1_data_WB=0x00400024 (Jal beats MemtoReg), RegWrite_WB=1. ALU op writing $0 -> RegWrite_WB=0.
5. Stall/flush: load a valid instruction, then assert stall for 3 cycles with changing inputs -> outputs and retired_count frozen. Assert stall and flush together -> valid_WB=0, RegWrite_WB=0, retired_count unchanged.
6. Counter wrap with CNT_W=4: capture 17 valid instructions -> retired_count=1. Bubbles between them do not increment it.
